// File: rtl/boreal_envelope_scheduler.sv
// Round-robin scheduler feeding one shared square/EMA pipeline for NCH envelope trackers.
// Optional per-channel shift bank enabled by defining BOREAL_ENV_CFG_EN.
module boreal_envelope_scheduler #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned SHIFT = 6,
    localparam int unsigned CW   = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    in_valid,
    input  logic [24*NCH-1:0] in_data,
    output logic [NCH-1:0]    in_ready,
    input  logic              clr,
    input  logic              cfg_we,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [3:0]        cfg_shift,
    output logic              out_valid,
    output logic [CW-1:0]     out_ch,
    output logic [23:0]       out_env
);

    logic [CW-1:0]        ptr;
    logic [NCH-1:0]       grant_c;
    logic [CW-1:0]        gidx_c;
    logic [CW-1:0]        idx_c;
    logic                 found_c;
    logic [23:0]          samp [NCH];
    logic signed [47:0]   xe_c;
    logic [23:0]          mag_c;
    logic [15:0]          sq_lo_unused;
    logic [7:0]           sq_hi_unused;

    logic                 s1_valid, s2_valid;
    logic [CW-1:0]        s1_ch, s2_ch;
    logic [23:0]          s1_mag, s2_mag;
    logic [23:0]          env [NCH];

    logic [3:0]           sh_c;
    logic signed [24:0]   diff_c;
    logic signed [24:0]   upd_c;
    logic [23:0]          env_new_c;

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        assign samp[g] = in_data[24*g +: 24];
    end

    // First valid channel at or after ptr, wrapping; nothing granted while clearing.
    always_comb begin
        grant_c = '0;
        gidx_c  = '0;
        idx_c   = '0;
        found_c = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx_c = CW'((32'(ptr) + i) % NCH);
            if (!clr && !found_c && in_valid[idx_c]) begin
                found_c        = 1'b1;
                grant_c[idx_c] = 1'b1;
                gidx_c         = idx_c;
            end
        end
    end

    assign in_ready = grant_c;

    assign xe_c = 48'($signed(samp[gidx_c]));
    assign {sq_hi_unused, mag_c, sq_lo_unused} = xe_c * xe_c;

`ifdef BOREAL_ENV_CFG_EN
    logic [3:0] shift_q [NCH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) shift_q[i] <= 4'(SHIFT);
        end else if (cfg_we && (32'(cfg_ch) < NCH)) begin
            shift_q[cfg_ch] <= cfg_shift;
        end
    end

    assign sh_c = shift_q[s2_ch];
`else
    logic unused_cfg;
    assign unused_cfg = ^{cfg_we, cfg_ch, cfg_shift};
    assign sh_c       = 4'(SHIFT);
`endif

    // EMA step: env += (mag - env) >>> shift, floor rounding via arithmetic shift.
    assign diff_c    = $signed({1'b0, s2_mag}) - $signed({1'b0, env[s2_ch]});
    assign upd_c     = diff_c >>> sh_c;
    assign env_new_c = env[s2_ch] + 24'(upd_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            s1_valid  <= 1'b0;
            s1_ch     <= '0;
            s1_mag    <= '0;
            s2_valid  <= 1'b0;
            s2_ch     <= '0;
            s2_mag    <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_env   <= '0;
            for (int unsigned i = 0; i < NCH; i++) env[i] <= '0;
        end else begin
            s1_valid <= found_c;
            if (found_c) begin
                ptr    <= (32'(gidx_c) == NCH - 1) ? '0 : CW'(gidx_c + 1'b1);
                s1_ch  <= gidx_c;
                s1_mag <= mag_c;
            end
            s2_valid <= s1_valid;
            s2_ch    <= s1_ch;
            s2_mag   <= s1_mag;
            // Clear wins over the stage-2 write issued on the same edge.
            if (clr) begin
                out_valid <= 1'b0;
                for (int unsigned i = 0; i < NCH; i++) env[i] <= '0;
            end else if (s2_valid) begin
                env[s2_ch] <= env_new_c;
                out_valid  <= 1'b1;
                out_ch     <= s2_ch;
                out_env    <= env_new_c;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_boreal_envelope_scheduler.sv
// Randomized + directed bench for boreal_envelope_scheduler against a queue-based envelope model.
module tb_boreal_envelope_scheduler;

    localparam int NCH   = 4;
    localparam int SHIFT = 6;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     in_valid;
    logic [95:0]    in_data;
    logic [3:0]     in_ready;
    logic           clr;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [3:0]     cfg_shift;
    logic           out_valid;
    logic [1:0]     out_ch;
    logic [23:0]    out_env;

    boreal_envelope_scheduler #(.NCH(NCH), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .clr(clr), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_shift(cfg_shift), .out_valid(out_valid), .out_ch(out_ch), .out_env(out_env)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: accepted samples wait in a queue stamped with their accept edge,
    // and are applied to the envelope array two edges later.
    typedef struct {
        int ch;
        int mag;
        int edge_no;
    } item_t;

    item_t       pend[$];
    int          menv   [NCH];
    int          mshift [NCH];
    int          mptr;
    int          edge_n = 0;
    logic        obs_valid;
    logic [1:0]  obs_ch;
    logic [23:0] obs_env;
    logic [3:0]  obs_ready;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            menv[i]   = 0;
            mshift[i] = SHIFT;
        end
        mptr = 0;
        pend.delete();
    endtask

    function automatic int rr_pick(input logic [3:0] v, input logic c);
        if (c) return -1;
        for (int i = 0; i < NCH; i++) begin
            if (v[(mptr + i) % NCH]) return (mptr + i) % NCH;
        end
        return -1;
    endfunction

    function automatic int sq_mag(input logic [23:0] x);
        longint xs;
        longint sq;
        xs = longint'($signed(x));
        sq = xs * xs;
        return int'((sq >>> 16) & 64'hFFFFFF);
    endfunction

    function automatic logic [95:0] lane(input int ch, input logic [23:0] x);
        logic [95:0] d;
        d = '0;
        d[24*ch +: 24] = x;
        return d;
    endfunction

    task automatic cycle(input logic [3:0] v, input logic [95:0] d, input logic c,
                         input logic we, input logic [1:0] cch, input logic [3:0] csh);
        int    g;
        int    diff;
        int    exp_v, exp_ch, exp_env;
        item_t it;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        clr       = c;
        cfg_we    = we;
        cfg_ch    = cch;
        cfg_shift = csh;
        #1;
        g = rr_pick(v, c);
        obs_ready = in_ready;
        chk("in_ready", 32'(in_ready), (g < 0) ? 32'd0 : 32'(1 << g));
        @(posedge clk);
        edge_n++;
        exp_v = 0; exp_ch = 0; exp_env = 0;
        if (pend.size() > 0 && pend[0].edge_no == edge_n - 2) begin
            it = pend.pop_front();
            if (!c) begin
                diff = it.mag - menv[it.ch];
                menv[it.ch] = (menv[it.ch] + (diff >>> mshift[it.ch])) & 32'hFFFFFF;
                exp_v   = 1;
                exp_ch  = it.ch;
                exp_env = menv[it.ch];
            end
        end
        if (c) for (int i = 0; i < NCH; i++) menv[i] = 0;
`ifdef BOREAL_ENV_CFG_EN
        if (we) mshift[cch] = int'(csh);
`endif
        if (g >= 0) begin
            mptr       = (g + 1) % NCH;
            it.ch      = g;
            it.mag     = sq_mag(d[24*g +: 24]);
            it.edge_no = edge_n;
            pend.push_back(it);
        end
        #1;
        obs_valid = out_valid;
        obs_ch    = out_ch;
        obs_env   = out_env;
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        if (exp_v != 0) begin
            chk("out_ch", 32'(out_ch), 32'(exp_ch));
            chk("out_env", 32'(out_env), 32'(exp_env));
        end
    endtask

    task automatic idle();
        cycle(4'h0, '0, 1'b0, 1'b0, 2'd0, 4'd0);
    endtask

    task automatic send(input int ch, input logic [23:0] x);
        cycle(4'(1 << ch), lane(ch, x), 1'b0, 1'b0, 2'd0, 4'd0);
    endtask

    function automatic logic [95:0] rand_data();
        logic [95:0] d;
        logic [23:0] x;
        for (int i = 0; i < NCH; i++) begin
            x = 24'($urandom);
            if ($urandom_range(0, 1) == 1) x = {{11{x[12]}}, x[12:0]};
            d[24*i +: 24] = x;
        end
        return d;
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = '0; in_data = '0; clr = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_shift = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_out_env", 32'(out_env), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single sample and repeat, then the negative input.
        send(0, 24'h001000); idle(); idle();
        chk("first_valid", 32'(obs_valid), 1);
        chk("first_env", 32'(obs_env), 4);
        send(0, 24'h001000); idle(); idle();
        chk("second_env", 32'(obs_env), 7);
        cycle(4'h0, '0, 1'b1, 1'b0, 2'd0, 4'd0);
        send(0, 24'hFFF000); idle(); idle();
        chk("neg_first_env", 32'(obs_env), 4);
        send(0, 24'hFFF000); idle(); idle();
        chk("neg_second_env", 32'(obs_env), 7);
        send(0, 24'h000000); idle(); idle();
        chk("decay_floor_env", 32'(obs_env), 6);

`ifdef BOREAL_ENV_CFG_EN
        cycle(4'h0, '0, 1'b0, 1'b1, 2'd1, 4'd0);
        send(1, 24'h001000); idle(); idle();
        chk("cfg_load_env", 32'(obs_env), 256);
        cycle(4'h0, '0, 1'b0, 1'b1, 2'd1, 4'd6);
        send(1, 24'h000000); idle(); idle();
        chk("decay256_env", 32'(obs_env), 252);
`endif

        // Only ch2 valid: granted every cycle, consecutive updates.
        send(2, 24'h001000); send(2, 24'h001000); send(2, 24'h001000);
        chk("ch2_ready", 32'(obs_ready), 4);
        chk("ch2_env0", 32'(obs_env), 4);
        send(2, 24'h001000);
        chk("ch2_env1", 32'(obs_env), 7);
        idle();
        chk("ch2_env2", 32'(obs_env), 10);
        idle();
        chk("ch2_env3", 32'(obs_env), 13);

        // clr with ch0 in stage 2 and ch1 in stage 1.
        send(0, 24'h001000); send(1, 24'h001000);
        cycle(4'h0, '0, 1'b1, 1'b0, 2'd0, 4'd0);
        chk("clr_drop_valid", 32'(obs_valid), 0);
        idle();
        chk("clr_ch1_ch", 32'(obs_ch), 1);
        chk("clr_ch1_env", 32'(obs_env), 4);
        send(0, 24'h001000); idle(); idle();
        chk("clr_ch0_env", 32'(obs_env), 4);

`ifdef BOREAL_ENV_CFG_EN
        send(3, 24'h001000); idle();
        cycle(4'h0, '0, 1'b0, 1'b1, 2'd3, 4'd0);
        chk("cfg_same_edge_env", 32'(obs_env), 4);
        send(3, 24'h001000); idle(); idle();
        chk("cfg_after_env", 32'(obs_env), 256);
`endif

        // Asynchronous reset mid-stream.
        repeat (3) cycle(4'hF, rand_data(), 1'b0, 1'b0, 2'd0, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_env", 32'(out_env), 0);
        chk("async_rst_ch", 32'(out_ch), 0);
        chk("async_rst_ready", 32'(in_ready), 1);
        in_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) idle();
        chk("post_rst_no_stale", 32'(obs_valid), 0);

        // All channels valid: grant order 0,1,2,3,0,1,2,3.
        for (int i = 0; i < 8; i++) begin
            cycle(4'hF, rand_data(), 1'b0, 1'b0, 2'd0, 4'd0);
            chk("rr_order", 32'(obs_ready), 32'(1 << (i % 4)));
        end

        // Randomized traffic with occasional clears and config writes.
        for (int n = 0; n < 1500; n++) begin
            cycle(4'($urandom), rand_data(),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 7) == 0),
                  2'($urandom), 4'($urandom));
        end
        repeat (3) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
